// File: rtl/exception_ctrl_pkg.sv
// Shared types and constants for the exception sequencer.
// EStatus encodings match the main decoder's Exc/EStatus outputs.
package exc_pkg;

   typedef enum logic {ST_RUN, ST_HANDLER} exc_state_t;

   localparam logic [3:0] ESTAT_NONE  = 4'h0;
   localparam logic [3:0] ESTAT_IRQ   = 4'h1;
   localparam logic [3:0] ESTAT_BADOP = 4'h2;

endpackage

// File: rtl/exception_ctrl_if.sv
// Decoder/fetch-side signal bundle of the exception sequencer.
// slave = exception_ctrl side, master = decoder/fetch side.
interface exception_ctrl_if #(
   parameter int XLEN = 64
);
   logic            exc;
   logic [3:0]      estatus;
   logic            eret;
   logic [XLEN-1:0] pc;
   logic            ext_irq;
   logic            pc_redirect;
   logic [XLEN-1:0] pc_target;
   logic [XLEN-1:0] elr;
   logic [XLEN-1:0] esr;
   logic            in_handler;
   logic            dfault;

   modport slave (
      input  exc, estatus, eret, pc,
      output ext_irq, pc_redirect, pc_target, elr, esr, in_handler, dfault
   );

   modport master (
      output exc, estatus, eret, pc,
      input  ext_irq, pc_redirect, pc_target, elr, esr, in_handler, dfault
   );
endinterface

// File: rtl/exception_ctrl_irq_sync.sv
// irq_in synchronizer chain followed by a rising-edge detector.
// irq_rise is high for one cycle after the synced level goes 0->1.
module irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic irq_in,
   output logic irq_rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign irq_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer: IRQ conditioning, ELR/ESR, RUN/HANDLER FSM
// and PC redirection. Define EXC_COUNT_EN to add the exc_count output.
//
// state      | meaning
// ST_RUN     | normal execution, IRQs unmasked
// ST_HANDLER | inside exception handler, IRQs masked, exc here is a double fault
module exception_ctrl
   import exc_pkg::*;
#(
   parameter int              XLEN        = 64,
   parameter logic [XLEN-1:0] VECTOR_BASE = 64'hD8,
   parameter int              SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     irq_in,
`ifdef EXC_COUNT_EN
   output logic [31:0]              exc_count,
`endif
   exception_ctrl_if.slave          bus
);

   exc_state_t      state_q, state_d;
   logic [XLEN-1:0] elr_q, elr_d;
   logic [XLEN-1:0] esr_q, esr_d;
   logic            dfault_q, dfault_d;
   logic            pending_q, pending_d;
   logic            irq_rise;
   logic            redirect;
   logic [XLEN-1:0] target;

   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
      .clk      (clk),
      .reset    (reset),
      .irq_in   (irq_in),
      .irq_rise (irq_rise)
   );

   always_comb begin
      state_d   = state_q;
      elr_d     = elr_q;
      esr_d     = esr_q;
      dfault_d  = dfault_q;
      pending_d = pending_q;
      redirect  = 1'b0;
      target    = '0;

      unique case (state_q)
         ST_RUN: begin
            if (bus.exc) begin
               redirect = 1'b1;
               target   = VECTOR_BASE;
               elr_d    = bus.pc;
               esr_d    = {{(XLEN-4){1'b0}}, bus.estatus};
               state_d  = ST_HANDLER;
               if (bus.estatus == ESTAT_IRQ)
                  pending_d = 1'b0;
            end else if (bus.eret) begin
               redirect = 1'b1;
               target   = elr_q;
            end
         end
         ST_HANDLER: begin
            if (bus.exc) begin
               redirect = 1'b1;
               target   = VECTOR_BASE;
               dfault_d = 1'b1;
            end else if (bus.eret) begin
               redirect = 1'b1;
               target   = elr_q;
               state_d  = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase

      // A fresh edge must not be swallowed by the clear of the IRQ being taken.
      if (irq_rise)
         pending_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RUN;
         elr_q     <= '0;
         esr_q     <= '0;
         dfault_q  <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         elr_q     <= elr_d;
         esr_q     <= esr_d;
         dfault_q  <= dfault_d;
         pending_q <= pending_d;
      end
   end

`ifdef EXC_COUNT_EN
   logic [31:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (bus.exc)
         count_d = count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign exc_count = count_q;
`endif

   // Redirect is combinational; reset suppresses it so fetch sees a clean start.
   assign bus.pc_redirect = redirect & ~reset;
   assign bus.pc_target   = reset ? '0 : target;
   assign bus.ext_irq     = pending_q & (state_q == ST_RUN);
   assign bus.elr         = elr_q;
   assign bus.esr         = esr_q;
   assign bus.in_handler  = (state_q == ST_HANDLER);
   assign bus.dfault      = dfault_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: expectations are queued as stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_exception_ctrl;

   logic clk;
   logic reset;
   logic irq_in;
`ifdef EXC_COUNT_EN
   logic [31:0] exc_count;
`endif

   exception_ctrl_if #(.XLEN(64)) bus ();

   exception_ctrl #(
      .XLEN        (64),
      .VECTOR_BASE (64'hD8),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .irq_in    (irq_in),
`ifdef EXC_COUNT_EN
      .exc_count (exc_count),
`endif
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic push(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic chk(input logic [63:0] obs);
      exp_t e;
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL sb_underflow observed=%0h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      reset       = 1'b1;
      irq_in      = 1'b0;
      bus.exc     = 1'b0;
      bus.estatus = 4'h0;
      bus.eret    = 1'b0;
      bus.pc      = '0;
      steps(2);
      reset = 1'b0;

      // Reset state
      push("rst_ext_irq", 0); push("rst_redirect", 0); push("rst_target", 0);
      push("rst_elr", 0); push("rst_esr", 0); push("rst_in_handler", 0);
      push("rst_dfault", 0);
      #1;
      chk(bus.ext_irq); chk(bus.pc_redirect); chk(bus.pc_target);
      chk(bus.elr); chk(bus.esr); chk(bus.in_handler); chk(bus.dfault);

      // 1: irq_in to ext_irq takes exactly 3 edges
      irq_in = 1'b1;
      push("irq_lat_e1", 0); step(); chk(bus.ext_irq);
      push("irq_lat_e2", 0); step(); chk(bus.ext_irq);
      push("irq_lat_e3", 1); step(); chk(bus.ext_irq);

      // 2: take IRQ from RUN
      bus.pc = 64'h40; bus.exc = 1'b1; bus.estatus = 4'h1;
      push("t2_redirect", 1); push("t2_target", 64'hD8);
      #1; chk(bus.pc_redirect); chk(bus.pc_target);
      push("t2_elr", 64'h40); push("t2_esr", 1); push("t2_in_handler", 1);
      push("t2_ext_irq", 0);
      step(); bus.exc = 1'b0; bus.estatus = 4'h0;
      chk(bus.elr); chk(bus.esr); chk(bus.in_handler); chk(bus.ext_irq);

      // 3: new IRQ edge while masked, then ERET exposes it
      irq_in = 1'b0; steps(3);
      irq_in = 1'b1;
      push("t3_masked", 0); steps(4); chk(bus.ext_irq);
      bus.eret = 1'b1;
      push("t3_redirect", 1); push("t3_target", 64'h40);
      #1; chk(bus.pc_redirect); chk(bus.pc_target);
      push("t3_in_handler", 0); push("t3_ext_irq", 1);
      step(); bus.eret = 1'b0;
      chk(bus.in_handler); chk(bus.ext_irq);

      // 4: double fault in HANDLER leaves elr/esr alone
      bus.pc = 64'h40; bus.exc = 1'b1; bus.estatus = 4'h1;
      step();
      bus.pc = 64'h100; bus.exc = 1'b1; bus.estatus = 4'h2;
      push("t4_redirect", 1); push("t4_target", 64'hD8);
      #1; chk(bus.pc_redirect); chk(bus.pc_target);
      push("t4_elr", 64'h40); push("t4_esr", 1); push("t4_dfault", 1);
      push("t4_in_handler", 1);
      step(); bus.exc = 1'b0; bus.estatus = 4'h0;
      chk(bus.elr); chk(bus.esr); chk(bus.dfault); chk(bus.in_handler);

      // ERET back to RUN, then 5: exc beats eret
      bus.eret = 1'b1; step(); bus.eret = 1'b0;
      bus.pc = 64'h20; bus.exc = 1'b1; bus.eret = 1'b1; bus.estatus = 4'h2;
      push("t5_redirect", 1); push("t5_target", 64'hD8);
      #1; chk(bus.pc_redirect); chk(bus.pc_target);
      push("t5_elr", 64'h20); push("t5_esr", 2); push("t5_in_handler", 1);
      push("t5_dfault_sticky", 1);
      step(); bus.exc = 1'b0; bus.eret = 1'b0; bus.estatus = 4'h0;
      chk(bus.elr); chk(bus.esr); chk(bus.in_handler); chk(bus.dfault);

      // ERET in RUN redirects to elr and stays in RUN
      bus.eret = 1'b1; step();
      push("run_eret_redirect", 1); push("run_eret_target", 64'h20);
      #1; chk(bus.pc_redirect); chk(bus.pc_target);
      push("run_eret_in_handler", 0);
      step(); bus.eret = 1'b0; chk(bus.in_handler);

      // New IRQ edge on the same edge an IRQ is taken: pending survives
      irq_in = 1'b0; steps(3);
      irq_in = 1'b1; steps(2);
      bus.pc = 64'h80; bus.exc = 1'b1; bus.estatus = 4'h1;
      push("edge_take_masked", 0);
      step(); bus.exc = 1'b0; bus.estatus = 4'h0; chk(bus.ext_irq);
      bus.eret = 1'b1;
      push("edge_take_pending", 1);
      step(); bus.eret = 1'b0; chk(bus.ext_irq);

      // Bad opcode from RUN keeps pending; ends up in HANDLER with pending=1
      bus.pc = 64'h88; bus.exc = 1'b1; bus.estatus = 4'h2;
      push("t6_in_handler", 1);
      step(); bus.exc = 1'b0; bus.estatus = 4'h0; chk(bus.in_handler);
`ifdef EXC_COUNT_EN
      push("cnt_before_reset", 6); chk({32'h0, exc_count});
`endif

      // 6: reset from HANDLER with pending, exc held to show reset wins
      irq_in = 1'b0; reset = 1'b1; bus.exc = 1'b1; bus.estatus = 4'h2;
      push("t6_rst_redirect", 0);
      #1; chk(bus.pc_redirect);
      push("t6_in_handler", 0); push("t6_ext_irq", 0); push("t6_elr", 0);
      push("t6_esr", 0); push("t6_dfault", 0);
      step();
      chk(bus.in_handler); chk(bus.ext_irq); chk(bus.elr); chk(bus.esr);
      chk(bus.dfault);
`ifdef EXC_COUNT_EN
      push("cnt_after_reset", 0); chk({32'h0, exc_count});
`endif
      reset = 1'b0; bus.exc = 1'b0; bus.estatus = 4'h0;
      push("t6_pending_cleared", 0);
      steps(4); chk(bus.ext_irq);

      if (sb.size() != 0) begin
         n_fail++;
         $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
